// File: rtl/seq_multiplier_8bit.sv
// Sequential shift-and-add unsigned multiplier: one partial product per clock,
// 2*WIDTH-bit product with a one-cycle done pulse.
module seq_multiplier_8bit #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     numberA,
  input  logic [WIDTH-1:0]     numberB,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum_bits;
  logic             carry;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mq_next;
  logic             last_step;

  // Ripple-carry adder chain; the carry out is kept and shifted into acc.
  always_comb begin
    addend   = mq[0] ? mcand : '0;
    sum_bits = '0;
    carry    = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_bits[i] = acc[i] ^ addend[i] ^ carry;
      carry       = (acc[i] & addend[i]) | (carry & (acc[i] ^ addend[i]));
    end
    acc_next  = {carry, sum_bits[WIDTH-1:1]};
    mq_next   = {sum_bits[0], mq[WIDTH-1:1]};
    last_step = (count == CW'(WIDTH - 1));
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      acc     <= '0;
      mq      <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= numberA;
            mq    <= numberB;
            acc   <= '0;
            count <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc   <= acc_next;
          mq    <= mq_next;
          count <= count + 1'b1;
          if (last_step) begin
            product <= {acc_next, mq_next};
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
